pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Purpose: multi-cycle RV32I control FSM; owns all program-counter updates, memory handshakes and the retire counter.
// Latency: ready tied high gives BRANCH/illegal 3 cycles, ALU/JUMP/STORE 4 cycles, LOAD 5 cycles.
// Backpressure: holds in FETCH until imem_ready and in MEM until dmem_ready; ready seen outside its state is dropped.
//
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   curr_addr         - current PC from the PC register
//   target_addr       - branch/JAL/JALR target, valid in EXECUTE and WB
//   opcode            - instr[6:0], stable from DECODE until the next FETCH
//   branch_taken      - branch comparator result, valid in EXECUTE
//   imem_ready        - instruction memory data valid
//   dmem_ready        - data memory access complete
//   imem_req/ir_write - fetch request / IR load strobe
//   dmem_req/dmem_we  - data memory request / store
//   rf_write          - register-file write enable
//   PC_Update         - PC load strobe, once per instruction
//   next_addr         - PC load value (curr_addr+4 when PC_Update is low)
//   trap              - illegal-instruction pulse
//   state             - current FSM state (debug)
//   instret           - retired-instruction count
module pc_sequencer #(
    parameter int                   BUS_WIDTH   = 32,
    parameter logic [BUS_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] curr_addr,
    input  logic [BUS_WIDTH-1:0] target_addr,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 rf_write,
    output logic                 PC_Update,
    output logic [BUS_WIDTH-1:0] next_addr,
    output logic                 trap,
    output logic [2:0]           state,
    output logic [31:0]          instret
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_TRAP    = 3'd5;

    localparam logic [BUS_WIDTH-1:0] PC_STEP = BUS_WIDTH'(4);

    logic [2:0]  state_q, state_d;
    logic [31:0] instret_q;

    // Opcode classification
    logic is_alu, is_load, is_store, is_branch, is_jump, is_legal;
    always_comb begin
        is_alu    = (opcode == 7'b0110011) || (opcode == 7'b0010011) ||
                    (opcode == 7'b0110111) || (opcode == 7'b0010111);
        is_load   = (opcode == 7'b0000011);
        is_store  = (opcode == 7'b0100011);
        is_branch = (opcode == 7'b1100011);
        is_jump   = (opcode == 7'b1101111) || (opcode == 7'b1100111);
        is_legal  = is_alu | is_load | is_store | is_branch | is_jump;
    end

    // Sequential PC; wraps naturally at the bus width
    logic [BUS_WIDTH-1:0] seq_addr;
    assign seq_addr = curr_addr + PC_STEP;

    // Ungated control decode
    logic                 imem_req_c, ir_write_c, dmem_req_c, dmem_we_c;
    logic                 rf_write_c, pc_update_c, trap_c;
    logic [BUS_WIDTH-1:0] next_addr_c;

    always_comb begin
        state_d     = state_q;
        imem_req_c  = 1'b0;
        ir_write_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        rf_write_c  = 1'b0;
        pc_update_c = 1'b0;
        trap_c      = 1'b0;
        next_addr_c = seq_addr;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = is_legal ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                if (is_branch) begin
                    pc_update_c = 1'b1;
                    if (branch_taken) begin
                        next_addr_c = target_addr;
                    end
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    // ALU or JUMP; illegal opcodes never reach EXECUTE
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        // Stores have nothing to write back, so they retire here
                        pc_update_c = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_write_c  = 1'b1;
                pc_update_c = 1'b1;
                if (is_jump) begin
                    next_addr_c = target_addr;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap_c      = 1'b1;
                pc_update_c = 1'b1;
                next_addr_c = TRAP_VECTOR;
                state_d     = S_FETCH;
            end
            default: begin
                // Unused codes 6 and 7 recover to FETCH
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Trap PC loads do not retire an instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (pc_update_c && !trap_c) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    // Gate every output with reset so they collapse to zero the moment rst falls
    assign imem_req  = rst & imem_req_c;
    assign ir_write  = rst & ir_write_c;
    assign dmem_req  = rst & dmem_req_c;
    assign dmem_we   = rst & dmem_we_c;
    assign rf_write  = rst & rf_write_c;
    assign PC_Update = rst & pc_update_c;
    assign trap      = rst & trap_c;
    assign next_addr = rst ? next_addr_c : '0;
    assign state     = rst ? state_q : 3'd0;
    assign instret   = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed self-checking bench for pc_sequencer.
// Latency: inputs driven on the falling edge, outputs sampled 1ns later.
// Backpressure: exercises imem_ready and dmem_ready stalls plus a mid-MEM reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] curr_addr, target_addr;
    logic [6:0]  opcode;
    logic        branch_taken, imem_ready, dmem_ready;
    logic        imem_req, ir_write, dmem_req, dmem_we, rf_write, PC_Update, trap;
    logic [31:0] next_addr;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instret = 32'd0;

    // Control vector: {imem_req, ir_write, dmem_req, dmem_we, rf_write, PC_Update, trap}
    localparam logic [6:0] C_IMEM = 7'b1000000;
    localparam logic [6:0] C_IRW  = 7'b0100000;
    localparam logic [6:0] C_DREQ = 7'b0010000;
    localparam logic [6:0] C_DWE  = 7'b0001000;
    localparam logic [6:0] C_RFW  = 7'b0000100;
    localparam logic [6:0] C_PCU  = 7'b0000010;
    localparam logic [6:0] C_TRAP = 7'b0000001;

    logic [6:0] ctl;
    assign ctl = {imem_req, ir_write, dmem_req, dmem_we, rf_write, PC_Update, trap};

    always #5 clk = ~clk;

    pc_sequencer #(.BUS_WIDTH(32), .TRAP_VECTOR(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .curr_addr(curr_addr), .target_addr(target_addr),
        .opcode(opcode), .branch_taken(branch_taken), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_write(ir_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_write(rf_write),
        .PC_Update(PC_Update), .next_addr(next_addr), .trap(trap),
        .state(state), .instret(instret)
    );

    task automatic test_reset();
        rst = 1'b0; curr_addr = 32'h1234; target_addr = 32'h5678; opcode = 7'b0110011;
        branch_taken = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || ctl !== 7'd0 || next_addr !== 32'd0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_init state=%0d ctl=%b na=%h instret=%0d want 0/0/0/0", state, ctl, next_addr, instret);
        end
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd0 || ctl !== 7'd0 || next_addr !== 32'd0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold state=%0d ctl=%b na=%h instret=%0d want 0/0/0/0", state, ctl, next_addr, instret);
        end
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic test_alu();
        logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic [6:0]  ec [4] = '{C_IMEM | C_IRW, 7'd0, 7'd0, C_RFW | C_PCU};
        curr_addr = 32'h0; target_addr = 32'hDEAD_0000; opcode = 7'b0110011; imem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++;
            if (state !== es[c] || ctl !== ec[c] || next_addr !== 32'h4) begin
                errors++;
                $display("FAIL alu c%0d state=%0d ctl=%b na=%h want %0d %b 00000004", c, state, ctl, next_addr, es[c], ec[c]);
            end
        end
        exp_instret++;
        @(posedge clk); #1;
        checks++;
        if (instret !== exp_instret || state !== 3'd0) begin
            errors++;
            $display("FAIL alu_retire instret=%0d state=%0d want %0d 0", instret, state, exp_instret);
        end
    endtask

    task automatic test_branch();
        logic [2:0]  es [3] = '{3'd0, 3'd1, 3'd2};
        logic [6:0]  ec [3] = '{C_IMEM | C_IRW, 7'd0, C_PCU};
        logic [31:0] en [3];
        curr_addr = 32'h40; target_addr = 32'h20; opcode = 7'b1100011; imem_ready = 1'b1;
        for (int t = 1; t >= 0; t--) begin
            branch_taken = (t == 1);
            en = '{32'h44, 32'h44, (t == 1) ? 32'h20 : 32'h44};
            for (int c = 0; c < 3; c++) begin
                @(negedge clk); #1;
                checks++;
                if (state !== es[c] || ctl !== ec[c] || next_addr !== en[c]) begin
                    errors++;
                    $display("FAIL branch t%0d c%0d state=%0d ctl=%b na=%h want %0d %b %h", t, c, state, ctl, next_addr, es[c], ec[c], en[c]);
                end
            end
            exp_instret++;
            @(posedge clk); #1;
            checks++;
            if (instret !== exp_instret || state !== 3'd0) begin
                errors++;
                $display("FAIL branch_retire t%0d instret=%0d state=%0d want %0d 0", t, instret, state, exp_instret);
            end
        end
    endtask

    task automatic test_load_stall();
        logic [2:0] es [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic [6:0] ec [8] = '{C_IMEM | C_IRW, 7'd0, 7'd0, C_DREQ, C_DREQ, C_DREQ, C_DREQ, C_RFW | C_PCU};
        curr_addr = 32'h200; target_addr = 32'h999; opcode = 7'b0000011; imem_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            // ready high before MEM must be ignored
            dmem_ready = (c < 3) || (c == 6);
            #1;
            checks++;
            if (state !== es[c] || ctl !== ec[c] || next_addr !== 32'h204) begin
                errors++;
                $display("FAIL load c%0d state=%0d ctl=%b na=%h want %0d %b 00000204", c, state, ctl, next_addr, es[c], ec[c]);
            end
        end
        exp_instret++;
        @(posedge clk); #1;
        checks++;
        if (instret !== exp_instret || state !== 3'd0) begin
            errors++;
            $display("FAIL load_retire instret=%0d state=%0d want %0d 0", instret, state, exp_instret);
        end
    endtask

    task automatic test_store_stall();
        logic [2:0] es [9] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
        logic [6:0] ec [9] = '{C_IMEM, C_IMEM, C_IMEM | C_IRW, 7'd0, 7'd0,
                               C_DREQ | C_DWE, C_DREQ | C_DWE, C_DREQ | C_DWE, C_DREQ | C_DWE | C_PCU};
        curr_addr = 32'h200; target_addr = 32'h999; opcode = 7'b0100011;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            imem_ready = (c == 2);
            dmem_ready = (c < 5) || (c == 8);
            #1;
            checks++;
            if (state !== es[c] || ctl !== ec[c] || next_addr !== 32'h204) begin
                errors++;
                $display("FAIL store c%0d state=%0d ctl=%b na=%h want %0d %b 00000204", c, state, ctl, next_addr, es[c], ec[c]);
            end
        end
        exp_instret++;
        @(posedge clk); #1;
        checks++;
        if (instret !== exp_instret || state !== 3'd0) begin
            errors++;
            $display("FAIL store_retire instret=%0d state=%0d want %0d 0", instret, state, exp_instret);
        end
        imem_ready = 1'b1;
    endtask

    task automatic test_trap();
        logic [2:0]  es [3] = '{3'd0, 3'd1, 3'd5};
        logic [6:0]  ec [3] = '{C_IMEM | C_IRW, 7'd0, C_PCU | C_TRAP};
        logic [31:0] en [3] = '{32'h304, 32'h304, 32'h100};
        curr_addr = 32'h300; target_addr = 32'h40; opcode = 7'b1111111; imem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (state !== es[c] || ctl !== ec[c] || next_addr !== en[c]) begin
                errors++;
                $display("FAIL trap c%0d state=%0d ctl=%b na=%h want %0d %b %h", c, state, ctl, next_addr, es[c], ec[c], en[c]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (instret !== exp_instret || state !== 3'd0) begin
            errors++;
            $display("FAIL trap_noretire instret=%0d state=%0d want %0d 0", instret, state, exp_instret);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [2:0] es [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic [6:0] ec [4] = '{C_IMEM | C_IRW, 7'd0, 7'd0, C_RFW | C_PCU};
        logic [6:0] ops [2] = '{7'b1101111, 7'b0110011};
        curr_addr = 32'hFFFF_FFFC; target_addr = 32'h80; imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i];
            for (int c = 0; c < 4; c++) begin
                logic [31:0] en;
                en = (i == 0 && c == 3) ? 32'h80 : 32'h0;
                @(negedge clk); #1;
                checks++;
                if (state !== es[c] || ctl !== ec[c] || next_addr !== en) begin
                    errors++;
                    $display("FAIL wrap i%0d c%0d state=%0d ctl=%b na=%h want %0d %b %h", i, c, state, ctl, next_addr, es[c], ec[c], en);
                end
            end
            exp_instret++;
            @(posedge clk); #1;
            checks++;
            if (instret !== exp_instret || state !== 3'd0) begin
                errors++;
                $display("FAIL wrap_retire i%0d instret=%0d state=%0d want %0d 0", i, instret, state, exp_instret);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        curr_addr = 32'h500; target_addr = 32'h0; opcode = 7'b0000011; imem_ready = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (state !== 3'd3 || ctl !== C_DREQ || instret === 32'd0) begin
            errors++;
            $display("FAIL rmid_pre state=%0d ctl=%b instret=%0d want 3 %b nonzero", state, ctl, instret, C_DREQ);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || ctl !== 7'd0 || next_addr !== 32'd0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL rmid_async state=%0d ctl=%b na=%h instret=%0d want 0/0/0/0", state, ctl, next_addr, instret);
        end
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd0 || ctl !== 7'd0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL rmid_hold state=%0d ctl=%b instret=%0d want 0/0/0", state, ctl, instret);
        end
        exp_instret = 32'd0;
        imem_ready = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (state !== 3'd0 || ctl !== C_IMEM || next_addr !== 32'h504 || instret !== 32'd0) begin
            errors++;
            $display("FAIL rmid_release state=%0d ctl=%b na=%h instret=%0d want 0 %b 00000504 0", state, ctl, next_addr, instret, C_IMEM);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load_stall();
        test_store_stall();
        test_trap();
        test_back_to_back_wrap();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
